// File: rtl/diffeq_pkg.sv
// Shared types and default sizing for the differential-equation solver.
package diffeq_pkg;

    localparam int unsigned DefWidth = 32;
    localparam int unsigned DefIterW = 16;

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StDone
    } state_e;

endpackage

// File: rtl/diffeq_step_dp.sv
// Combinational next-state datapath for one Euler step of y'' + 3xy' + 3y = 0.
module diffeq_step_dp #(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0] x_i,
    input  logic [Width-1:0] y_i,
    input  logic [Width-1:0] u_i,
    input  logic [Width-1:0] dx_i,
    output logic [Width-1:0] x_o,
    output logic [Width-1:0] y_o,
    output logic [Width-1:0] u_o
);

    localparam int unsigned NSlice = Width / 8;
    localparam logic [Width-1:0] Three = Width'(3);

    logic [Width-1:0] t, m_tx, m_dy, u_part;
    logic [NSlice:0]  c_x, c_y, c_u1, c_u2;
    logic             unused_carry;

    assign t    = u_i * dx_i;
    assign m_tx = Three * t * x_i;
    assign m_dy = Three * dx_i * y_i;

    // Subtractions are u + ~m + 1, so the u chains start with carry set.
    assign c_x[0]  = 1'b0;
    assign c_y[0]  = 1'b0;
    assign c_u1[0] = 1'b1;
    assign c_u2[0] = 1'b1;

    for (genvar i = 0; i < NSlice; i++) begin : g_slice
        dsp_adder u_add_x (
            .a_i     (x_i[8*i+:8]),
            .b_i     (dx_i[8*i+:8]),
            .carry_i (c_x[i]),
            .sum_o   (x_o[8*i+:8]),
            .carry_o (c_x[i+1])
        );
        dsp_adder u_add_y (
            .a_i     (y_i[8*i+:8]),
            .b_i     (t[8*i+:8]),
            .carry_i (c_y[i]),
            .sum_o   (y_o[8*i+:8]),
            .carry_o (c_y[i+1])
        );
        dsp_adder u_add_u1 (
            .a_i     (u_i[8*i+:8]),
            .b_i     (~m_tx[8*i+:8]),
            .carry_i (c_u1[i]),
            .sum_o   (u_part[8*i+:8]),
            .carry_o (c_u1[i+1])
        );
        dsp_adder u_add_u2 (
            .a_i     (u_part[8*i+:8]),
            .b_i     (~m_dy[8*i+:8]),
            .carry_i (c_u2[i]),
            .sum_o   (u_o[8*i+:8]),
            .carry_o (c_u2[i+1])
        );
    end

    assign unused_carry = ^{c_x[NSlice], c_y[NSlice], c_u1[NSlice], c_u2[NSlice]};

endmodule

// File: rtl/dsp_adder.sv
// 8-bit adder slice with carry in/out; chained to build wider adders.
module dsp_adder (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       carry_i,
    output logic [7:0] sum_o,
    output logic       carry_o
);

    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {8'd0, carry_i};

endmodule

// File: rtl/diffeq_solver_param.sv
// Iterative solver: accepts a job, steps until x >= a or the iteration limit, presents result.
module diffeq_solver_param
    import diffeq_pkg::*;
#(
    parameter int unsigned     WIDTH    = DefWidth,
    parameter int unsigned     ITER_W   = DefIterW,
    parameter longint unsigned MAX_ITER = (64'd1 << ITER_W) - 64'd1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  x_in,
    input  logic [WIDTH-1:0]  y_in,
    input  logic [WIDTH-1:0]  u_in,
    input  logic [WIDTH-1:0]  a_in,
    input  logic [WIDTH-1:0]  dx_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  x_out,
    output logic [WIDTH-1:0]  y_out,
    output logic [WIDTH-1:0]  u_out,
    output logic [ITER_W-1:0] iter_out,
    output logic              timeout
);

    localparam logic [ITER_W-1:0] MaxIter = ITER_W'(MAX_ITER);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  x_q, x_d, y_q, y_d, u_q, u_d, a_q, a_d, dx_q, dx_d;
    logic [WIDTH-1:0]  x_nxt, y_nxt, u_nxt;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic              timeout_q, timeout_d;

    diffeq_step_dp #(
        .Width (WIDTH)
    ) u_step_dp (
        .x_i  (x_q),
        .y_i  (y_q),
        .u_i  (u_q),
        .dx_i (dx_q),
        .x_o  (x_nxt),
        .y_o  (y_nxt),
        .u_o  (u_nxt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            x_q       <= '0;
            y_q       <= '0;
            u_q       <= '0;
            a_q       <= '0;
            dx_q      <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            u_q       <= u_d;
            a_q       <= a_d;
            dx_q      <= dx_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StIter;
            StIter:  if (x_q >= a_q || cnt_q == MaxIter) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        u_d       = u_q;
        a_d       = a_q;
        dx_d      = dx_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (state_q == StIdle && in_valid) begin
            x_d       = x_in;
            y_d       = y_in;
            u_d       = u_in;
            a_d       = a_in;
            dx_d      = dx_in;
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else if (state_q == StIter && x_q < a_q) begin
            // At the limit the state is frozen and only the abort flag is raised.
            if (cnt_q == MaxIter) begin
                timeout_d = 1'b1;
            end else begin
                x_d   = x_nxt;
                y_d   = y_nxt;
                u_d   = u_nxt;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        x_out     = x_q;
        y_out     = y_q;
        u_out     = u_q;
        iter_out  = cnt_q;
        timeout   = timeout_q;
    end

endmodule

// File: doc/diffeq_solver_param.md
DIFFEQ_SOLVER_PARAM -- requirements
Module: diffeq_solver_param

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits, a multiple of 8 and at least 8.
REQ-002 SHALL have parameter ITER_W, default 16, width of the iteration counter.
REQ-003 SHALL have parameter MAX_ITER, default 2**ITER_W-1, the iteration limit before a solve is aborted.
REQ-004 SHALL provide port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL provide port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL provide port in_valid, input, 1 bit: a job is offered.
REQ-007 SHALL provide port in_ready, output, 1 bit: a job can be accepted.
REQ-008 SHALL provide ports x_in, y_in, u_in, a_in, dx_in, input, WIDTH bits each: initial x, y, u, end point A, step DX.
REQ-009 SHALL provide port out_valid, output, 1 bit: the result is presented.
REQ-010 SHALL provide port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL provide ports x_out, y_out, u_out, output, WIDTH bits each: the final state.
REQ-012 SHALL provide port iter_out, output, ITER_W bits: the number of steps executed.
REQ-013 SHALL provide port timeout, output, 1 bit: the solve was aborted at MAX_ITER.

Function
REQ-014 SHALL implement FSM states IDLE, ITER and DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE; a handshake (in_valid and in_ready) SHALL capture all five inputs, clear the counter and enter ITER on the next cycle.
REQ-016 SHALL treat inputs as don't-care outside the accept cycle; a, dx held in internal registers.
REQ-017 In ITER, each cycle with x<a (unsigned) and count<MAX_ITER SHALL perform one step: t=u*dx; u<=u-3*t*x-3*dx*y; y<=y+t; x<=x+dx; count<=count+1.
REQ-018 SHALL compute all arithmetic modulo 2**WIDTH; subtraction SHALL be two's-complement addition; products SHALL be truncated to WIDTH bits.
REQ-019 In ITER with x>=a SHALL enter DONE with timeout=0; with x<a and count==MAX_ITER SHALL enter DONE with timeout=1; register state SHALL be unchanged on that cycle.
REQ-020 In DONE, out_valid=1 and x_out, y_out, u_out, iter_out, timeout SHALL be stable until out_ready=1, then return to IDLE on the next cycle.
REQ-021 SHALL have accept-to-out_valid latency of N+2 cycles for N steps; a job with x_in>=a_in gives N=0.
REQ-022 SHALL NOT accept a new job in the same cycle out_valid is handshaken; the earliest next accept is one cycle later.
REQ-023 Wrap-around of x past 2**WIDTH-1 SHALL follow the modulo rule of REQ-018 and rely on MAX_ITER to terminate.

Reset
REQ-024 SHALL, on reset=1 at a rising clk edge, force state IDLE and clear x, y, u, a, dx, the counter and timeout to 0 from any state, including mid-ITER and in DONE.
REQ-025 SHALL hold out_valid=0, in_ready=1 and x_out=y_out=u_out=iter_out=0 in the first cycle after reset.

Structure
REQ-026 SHALL place the state enum and the default WIDTH, ITER_W constants in the shared package diffeq_pkg.
REQ-027 SHALL implement one sub-module, diffeq_step_dp: combinational next-(x,y,u) datapath with additions built from chained 8-bit dsp_adder slices (WIDTH/8 per adder, ripple carry).

Verification (WIDTH=32 unless noted)
REQ-028 Job x=0,y=0,u=0,a=4,dx=1 -> x_out=4, y_out=0, u_out=0, iter_out=4, timeout=0, out_valid 6 cycles after accept.
REQ-029 Job x=0,y=1,u=1,a=1,dx=1 -> x_out=1, y_out=2, u_out=0xFFFFFFFE, iter_out=1.
REQ-030 Job x=5,a=5 -> outputs equal inputs, iter_out=0, out_valid 2 cycles after accept.
REQ-031 ITER_W=2, MAX_ITER=3, job x=0,a=10,dx=1 -> x_out=3, iter_out=3, timeout=1.
REQ-032 out_ready held low for 5 cycles in DONE -> outputs stable and in_ready=0 throughout; reset asserted mid-ITER -> IDLE next cycle with all outputs 0.
